// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus response controller.
package bus_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, ACK, BERR, DONE} bus_state_t;

  localparam logic [3:0] MISS_INDEX = 4'hF;

  // Counter must hold both the timeout bound and any fixed wait-state load.
  function automatic int cnt_width(input int timeout, input int wait_w);
    int w;
    w = $clog2(timeout + 1);
    return (w > wait_w) ? w : wait_w;
  endfunction

endpackage

// File: rtl/priority_select_encoder.sv
// Lowest-index-wins encoder over the decoder's slave selects.
module priority_select_encoder #(
  parameter int NUM_SLAVES = 8
) (
  input  logic [NUM_SLAVES-1:0] sel,
  output logic [3:0]            idx,
  output logic                  any,
  output logic                  multi
);

  always_comb begin
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (sel[i]) idx = 4'(i);
  end

  assign any   = |sel;
  assign multi = |(sel & (sel - NUM_SLAVES'(1)));

endmodule

// File: rtl/bus_response_controller.sv
// Registered slave read-data mux and DTAck generator with wait states,
// slave-driven acknowledge, timeout and decode-miss reporting.
module bus_response_controller
  import bus_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WAIT_WIDTH     = 4,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA   = '0
) (
  input  logic                             Clock,
  input  logic                             Reset_H,
  input  logic                             AS_L,
  input  logic                             WE_L,
  input  logic [NUM_SLAVES-1:0]            Select_H,
  input  logic [NUM_SLAVES-1:0]            Ack_Mode,
  input  logic [NUM_SLAVES*WAIT_WIDTH-1:0] Wait_States,
  input  logic [NUM_SLAVES-1:0]            Slave_Ack_H,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] DataIn_Slaves,
  input  logic                             Clear_Error_H,
  output logic [DATA_WIDTH-1:0]            DataOut_CPU,
  output logic                             DTAck_H,
  output logic                             Bus_Error_H,
  output logic                             Multi_Select_H,
  output logic [3:0]                       Error_Index
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, WAIT_WIDTH);

  bus_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0] idx_q, idx_nxt, eidx_nxt, enc_idx;
  logic read_q, read_nxt, mode_q, mode_nxt, miss_q, miss_nxt;
  logic dtack_nxt, berr_nxt, multi_nxt, enc_any, enc_multi;
  logic [DATA_WIDTH-1:0] data_nxt, cur_data;
  logic [WAIT_WIDTH-1:0] cap_wait;
  logic cap_mode, cur_ack;

  priority_select_encoder #(.NUM_SLAVES(NUM_SLAVES)) u_enc (
    .sel   (Select_H),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Capture-time fields follow the live encoder; in-flight fields follow the latched index.
  always_comb begin
    cap_mode = 1'b0;
    cap_wait = '0;
    cur_ack  = 1'b0;
    cur_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (enc_idx == 4'(i)) begin
        cap_mode = Ack_Mode[i];
        cap_wait = Wait_States[i*WAIT_WIDTH +: WAIT_WIDTH];
      end
      if (idx_q == 4'(i)) begin
        cur_ack  = Slave_Ack_H[i];
        cur_data = DataIn_Slaves[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    read_nxt  = read_q;
    mode_nxt  = mode_q;
    miss_nxt  = miss_q;
    data_nxt  = DataOut_CPU;
    dtack_nxt = 1'b0;
    berr_nxt  = 1'b0;
    multi_nxt = Multi_Select_H;
    eidx_nxt  = Error_Index;
    if (Clear_Error_H) begin
      multi_nxt = 1'b0;
      eidx_nxt  = '0;
    end
    case (state)
      IDLE: if (!AS_L) begin
        state_nxt = WAIT;
        idx_nxt   = enc_idx;
        read_nxt  = WE_L;
        mode_nxt  = cap_mode;
        miss_nxt  = !enc_any;
        cnt_nxt   = cap_mode ? '0 : CW'(cap_wait);
        if (enc_multi) begin
          multi_nxt = 1'b1;
          eidx_nxt  = enc_idx;
        end
      end
      WAIT: begin
        // A decode miss still spends one cycle here so the error lands at T+1.
        if (AS_L) begin
          state_nxt = IDLE;
        end else if (miss_q) begin
          state_nxt = BERR;
          dtack_nxt = 1'b1;
          berr_nxt  = 1'b1;
          data_nxt  = DEFAULT_DATA;
          eidx_nxt  = MISS_INDEX;
        end else if (mode_q ? cur_ack : (cnt == '0)) begin
          state_nxt = ACK;
          dtack_nxt = 1'b1;
          if (read_q) data_nxt = cur_data;
        end else if (!mode_q) begin
          cnt_nxt = cnt - CW'(1);
        end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          state_nxt = BERR;
          dtack_nxt = 1'b1;
          berr_nxt  = 1'b1;
          data_nxt  = DEFAULT_DATA;
          eidx_nxt  = idx_q;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACK, BERR: state_nxt = DONE;
      DONE: if (AS_L) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state          <= IDLE;
      cnt            <= '0;
      idx_q          <= '0;
      read_q         <= 1'b0;
      mode_q         <= 1'b0;
      miss_q         <= 1'b0;
      DataOut_CPU    <= '0;
      DTAck_H        <= 1'b0;
      Bus_Error_H    <= 1'b0;
      Multi_Select_H <= 1'b0;
      Error_Index    <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx_q          <= idx_nxt;
      read_q         <= read_nxt;
      mode_q         <= mode_nxt;
      miss_q         <= miss_nxt;
      DataOut_CPU    <= data_nxt;
      DTAck_H        <= dtack_nxt;
      Bus_Error_H    <= berr_nxt;
      Multi_Select_H <= multi_nxt;
      Error_Index    <= eidx_nxt;
    end
  end

endmodule

// File: tb/tb_bus_response_controller.sv
// Directed plus randomized bench; expected timing and data derived per access from the protocol rules.
module tb_bus_response_controller;

  localparam int NS = 8;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int TO = 8;
  localparam logic [DW-1:0] DEF = 32'hBAD0_0BAD;

  logic Clock = 1'b0;
  logic Reset_H, AS_L, WE_L, Clear_Error_H;
  logic [NS-1:0] Select_H, Ack_Mode, Slave_Ack_H;
  logic [NS*WW-1:0] Wait_States;
  logic [NS*DW-1:0] DataIn_Slaves;
  logic [DW-1:0] DataOut_CPU;
  logic DTAck_H, Bus_Error_H, Multi_Select_H;
  logic [3:0] Error_Index;

  bus_response_controller #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .WAIT_WIDTH(WW),
    .TIMEOUT_CYCLES(TO), .DEFAULT_DATA(DEF)
  ) dut (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .WE_L(WE_L),
    .Select_H(Select_H), .Ack_Mode(Ack_Mode), .Wait_States(Wait_States),
    .Slave_Ack_H(Slave_Ack_H), .DataIn_Slaves(DataIn_Slaves),
    .Clear_Error_H(Clear_Error_H), .DataOut_CPU(DataOut_CPU), .DTAck_H(DTAck_H),
    .Bus_Error_H(Bus_Error_H), .Multi_Select_H(Multi_Select_H), .Error_Index(Error_Index)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_data;
  logic exp_multi;
  logic [3:0] exp_eidx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_flags();
    chk("multi", 32'(Multi_Select_H), 32'(exp_multi));
    chk("eidx", 32'(Error_Index), 32'(exp_eidx));
    chk("data_hold", DataOut_CPU, exp_data);
  endtask

  task automatic clr();
    Clear_Error_H = 1'b1;
    @(negedge Clock);
    Clear_Error_H = 1'b0;
    exp_multi = 1'b0;
    exp_eidx  = 4'h0;
    chk("clr_multi", 32'(Multi_Select_H), 32'(exp_multi));
    chk("clr_eidx", 32'(Error_Index), 32'(exp_eidx));
  endtask

  // One CPU access. ad: first cycle after T with the slave ack high; ab: cycle AS_L is released (0 = never).
  task automatic txn(input logic [NS-1:0] sel, input logic [NS-1:0] amode, input logic [NS*WW-1:0] ws,
                     input logic we, input int ad, input int ab, input int hold, input logic [DW-1:0] dval);
    int lo, k, kend;
    logic any, multi, mode, err, aborted;
    logic [WW-1:0] w;
    lo = 0;
    for (int i = NS - 1; i >= 0; i--) if (sel[i]) lo = i;
    any   = (sel != '0);
    multi = ($countones(sel) > 1);
    mode  = any ? amode[lo] : 1'b0;
    w     = ws[lo*WW +: WW];
    err   = 1'b0;
    if (!any) begin k = 1; err = 1'b1; end
    else if (!mode) k = int'(w) + 1;
    else if (ad <= TO + 1) k = (ad < 1) ? 1 : ad;
    else begin k = TO + 1; err = 1'b1; end
    aborted = (ab > 0) && (ab <= k);
    kend = aborted ? ab : k;

    for (int i = 0; i < NS; i++) DataIn_Slaves[i*DW +: DW] = $urandom;
    if (any) DataIn_Slaves[lo*DW +: DW] = dval;
    AS_L = 1'b0; WE_L = we; Select_H = sel; Ack_Mode = amode; Wait_States = ws;
    Slave_Ack_H = NS'($urandom);
    @(negedge Clock);
    if (multi) begin exp_multi = 1'b1; exp_eidx = 4'(lo); end
    chk("dtack_at_T", 32'(DTAck_H), 0);
    chk("multi_at_T", 32'(Multi_Select_H), 32'(exp_multi));

    for (int j = 1; j <= kend; j++) begin
      Select_H = NS'($urandom); WE_L = 1'($urandom); Ack_Mode = NS'($urandom);
      Wait_States = (NS*WW)'({$urandom, $urandom}); Slave_Ack_H = NS'($urandom);
      if (any && mode) Slave_Ack_H[lo] = (j >= ad);
      if (aborted && j >= ab) AS_L = 1'b1;
      @(negedge Clock);
      if (!aborted && j == k) begin
        if (err) begin
          exp_data = DEF;
          exp_eidx = any ? 4'(lo) : 4'hF;
        end else if (we) exp_data = dval;
        chk("dtack", 32'(DTAck_H), 1);
        chk("berr", 32'(Bus_Error_H), 32'(err));
        chk("data", DataOut_CPU, exp_data);
        chk("eidx_resp", 32'(Error_Index), 32'(exp_eidx));
      end else begin
        chk("dtack_quiet", 32'(DTAck_H), 0);
      end
    end

    if (!aborted) begin
      for (int h = 0; h < hold; h++) begin
        Select_H = NS'($urandom); Slave_Ack_H = NS'($urandom);
        @(negedge Clock);
        chk("dtack_hold", 32'(DTAck_H), 0);
      end
    end
    AS_L = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      chk("dtack_gap", 32'(DTAck_H), 0);
    end
    chk_flags();
  endtask

  logic [NS*WW-1:0] ws;
  logic [NS-1:0] sel;

  initial begin
    Reset_H = 1'b1; AS_L = 1'b1; WE_L = 1'b1; Clear_Error_H = 1'b0;
    Select_H = '0; Ack_Mode = '0; Wait_States = '0; Slave_Ack_H = '0; DataIn_Slaves = '0;
    exp_data = '0; exp_multi = 1'b0; exp_eidx = 4'h0;
    repeat (2) @(negedge Clock);
    chk("rst_dtack", 32'(DTAck_H), 0);
    chk("rst_berr", 32'(Bus_Error_H), 0);
    chk_flags();
    Reset_H = 1'b0;
    @(negedge Clock);

    // fixed wait states, slave 2, W=3 -> DTAck at T+4
    ws = '0; ws[2*WW +: WW] = 4'd3;
    txn(8'b0000_0100, 8'h00, ws, 1'b1, 0, 0, 2, 32'hDEADBEEF);
    // slave-ack mode: ack at T+6, then timeout
    txn(8'b0010_0000, 8'b0010_0000, '0, 1'b1, 6, 0, 1, 32'h5555_AAAA);
    txn(8'b0010_0000, 8'b0010_0000, '0, 1'b1, 99, 0, 0, 32'h1111_2222);
    // decode miss with strobe held 10 cycles
    txn(8'h00, 8'h00, '0, 1'b1, 0, 0, 10, 32'h0);
    // multi-select, sticky until cleared
    clr();
    ws = '0; ws[2*WW +: WW] = 4'd1;
    txn(8'b0001_0100, 8'h00, ws, 1'b1, 0, 0, 0, 32'hCAFE_F00D);
    txn(8'b0000_1000, 8'h00, '0, 1'b1, 0, 0, 0, 32'h0BAD_CAFE);
    clr();
    // write leaves data alone; early strobe release aborts
    ws = '0; ws[1*WW +: WW] = 4'd0;
    txn(8'b0000_0010, 8'h00, ws, 1'b1, 0, 0, 0, 32'h0000_1234);
    ws[1*WW +: WW] = 4'd2;
    txn(8'b0000_0010, 8'h00, ws, 1'b0, 0, 0, 1, 32'hFFFF_0000);
    txn(8'b0000_0010, 8'h00, ws, 1'b0, 0, 1, 0, 32'hFFFF_0000);
    txn(8'b0000_0010, 8'h00, ws, 1'b1, 0, 2, 0, 32'h7777_7777);

    // async reset between edges while in WAIT
    ws = '0; ws[2*WW +: WW] = 4'd5;
    AS_L = 1'b0; WE_L = 1'b1; Select_H = 8'b0000_0100; Ack_Mode = '0; Wait_States = ws;
    repeat (2) @(negedge Clock);
    #2 Reset_H = 1'b1;
    #1;
    exp_data = '0; exp_multi = 1'b0; exp_eidx = 4'h0;
    chk("arst_dtack", 32'(DTAck_H), 0);
    chk("arst_berr", 32'(Bus_Error_H), 0);
    chk_flags();
    @(negedge Clock);
    Reset_H = 1'b0; AS_L = 1'b1;
    @(negedge Clock);
    ws = '0; ws[2*WW +: WW] = 4'd3;
    txn(8'b0000_0100, 8'h00, ws, 1'b1, 0, 0, 2, 32'hDEADBEEF);

    for (int t = 0; t < 60; t++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) sel = '0;
      else if (r <= 2) sel = NS'($urandom);
      else sel = NS'(1) << $urandom_range(0, NS - 1);
      if ($urandom_range(0, 4) == 0) clr();
      txn(sel, NS'($urandom), (NS*WW)'({$urandom, $urandom}), 1'($urandom),
          $urandom_range(1, TO + 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0,
          $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
